multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
// - Multicycle control FSM for the 8-bit Microprocessor datapath. Sequences fetch/decode/execute/mem/writeback per instruction.
// - Drives PC, IR, register-file, ALU-mux and data-memory enables; handshakes with a data memory that may stall.
// - Sits between IMEM/IR and the datapath; replaces single-cycle decode when data memory is not single-cycle.
// PARAMETERS
// - MEM_TIMEOUT  16  max cycles MEM waits for mem_ack before faulting (1..255)
// - CNT_W        8   width of retired-instruction counter
// PORTS
// - CLK          in   1      clock, rising edge
// - RST          in   1      async reset, active low
// - run          in   1      1 = free-run; 0 = stop at next instruction boundary
// - step         in   1      1-cycle pulse: execute one instruction while run=0
// - opcode       in   2      INSTR[7:6]: 00 add, 01 lw, 10 sw, 11 j
// - mem_ack      in   1      data memory done (rd data valid / write committed)
// - ir_we        out  1      load IR from IMEM
// - pc_we        out  1      update PC
// - pc_src       out  1      0 = PC+1, 1 = PC+1+sext(INSTR[5:0])
// - reg_we       out  1      register-file write enable
// - mem_to_reg   out  1      writeback source: 0 ALU, 1 READ_DATA
// - alu_src      out  1      ALU B: 0 register, 1 sext(INSTR[1:0])
// - mem_req      out  1      data memory request, held until ack
// - mem_we       out  1      write qualifier for mem_req
// - busy         out  1      1 while not in IDLE/FAULT
// - fault        out  1      sticky: memory timeout occurred
// - state        out  3      current state (debug / 7-seg)
// - retired      out  CNT_W  count of completed instructions
// BEHAVIOUR
// - Encoding: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 FAULT=7.
// - RST low: state=IDLE; all outputs 0; retired=0; fault=0; timeout counter=0. Takes effect immediately, incl. mid-MEM (mem_req drops async).
// - IDLE: -> FETCH if run=1 or step=1; else stay. busy=0.
// - FETCH (1 cyc): ir_we=1 -> DECODE.
// - DECODE (1 cyc): opcode taken from IR; no enables -> EXEC.
// - EXEC (1 cyc): add: alu_src=0 -> WB. lw/sw: alu_src=1 -> MEM (address calc).
// -   j: pc_we=1, pc_src=1, retired+=1 -> boundary.
// - MEM: mem_req=1, mem_we=(op==sw); held constant until ack. mem_ack seen in same cycle as mem_req counts.
// -   ack & lw -> WB (mem_to_reg=1 latched).
// -   ack & sw -> pc_we=1, pc_src=0, retired+=1 -> boundary.
// -   no ack: timeout counter +1; ack not seen by MEM_TIMEOUT cycles in MEM -> FAULT.
// -   Counter clears on MEM entry.
// - WB (1 cyc): reg_we=1, mem_to_reg=(op==lw), pc_we=1, pc_src=0, retired+=1 -> boundary.
// - Boundary: -> FETCH if run=1, else IDLE. A step pulse during an instruction is ignored, not queued.
// - FAULT: fault=1, mem_req=0, busy=0, all enables 0. Exit only via RST.
// - All enable outputs are Moore (decoded from state + latched opcode); ack timing does not glitch them.
// - mem_ack outside MEM ignored.
// - retired wraps 2^CNT_W-1 -> 0 silently.
// - Latency, no stall: add 4 cyc, j 3, sw 4, lw 5 (FETCH..WB inclusive).
// - Each MEM wait cycle adds 1.
// TESTING
// - Reset/idle: RST=0 then 1, run=0 -> state=0, all outputs 0, busy=0 for 20 cycles.
// - add: run=1, opcode=00 -> states 1,2,3,5,1; reg_we & pc_we high only in WB.
// -   After 3 adds, retired=3.
// - lw, ack delayed 3 cycles: mem_req high 4 cycles, mem_we=0; WB with mem_to_reg=1; total 8 cycles.
// - sw, ack same cycle: MEM 1 cycle, mem_we=1, pc_we=1, reg_we never high; retired+1.
// - Timeout: MEM_TIMEOUT=16, lw, ack held 0 -> FAULT after 16 MEM cycles; fault=1, mem_req=0.
// -   Stays there until RST low.
// - Step / reset: run=0, one step pulse -> exactly one add, then IDLE.
// -   RST low mid-MEM -> mem_req=0 before next edge; retired=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multicycle control FSM for the 8-bit microprocessor datapath. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, drives the datapath enables
// and handshakes with a data memory that may stall. A memory that never
// acknowledges parks the controller in a sticky FAULT state.
//
// Most outputs are registered: the next-state logic also decodes the enables
// for the state being entered, so they change only on the clock edge. The
// async reset clears them at once, which also drops mem_req mid-MEM.
// The one exception is pc_we for a store. A store retires in the MEM cycle
// in which mem_ack arrives, and that cycle is known only from mem_ack itself,
// so in MEM the pc_we for a store is qualified directly by mem_ack.

module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic             step,
  input  logic [1:0]       opcode,
  input  logic             mem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LW    = 2'b01;
  localparam logic [1:0] OP_SW    = 2'b10;
  localparam logic [1:0] OP_J     = 2'b11;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_r, state_s;
  logic [1:0]       op_r, op_s;
  logic [7:0]       tmo_r, tmo_s;
  logic             retire_s;
  logic [CNT_W-1:0] retired_r;

  logic ir_we_r, pc_we_r, pc_src_r, reg_we_r, mem_to_reg_r, alu_src_r;
  logic mem_req_r, mem_we_r, busy_r, fault_r;
  logic ir_we_s, pc_we_s, pc_src_s, reg_we_s, mem_to_reg_s, alu_src_s;
  logic mem_req_s, mem_we_s, busy_s, fault_s;
  logic sw_ack_s;

  // Next state, latched opcode, timeout counter, retire strobe, and the
  // enables belonging to the state being entered.
  always_comb begin
    state_s      = state_r;
    op_s         = op_r;
    tmo_s        = tmo_r;
    retire_s     = 1'b0;
    ir_we_s      = 1'b0;
    pc_we_s      = 1'b0;
    pc_src_s     = 1'b0;
    reg_we_s     = 1'b0;
    mem_to_reg_s = 1'b0;
    alu_src_s    = 1'b0;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    busy_s       = 1'b0;
    fault_s      = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (run || step) begin
          state_s = S_FETCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        state_s = S_DECODE;
      end
      S_DECODE: begin
        op_s    = opcode;
        state_s = S_EXEC;
      end
      S_EXEC: begin
        case (op_r)
          OP_ADD: state_s = S_WB;
          OP_LW, OP_SW: begin
            state_s = S_MEM;
            tmo_s   = 8'd0;
          end
          OP_J: begin
            retire_s = 1'b1;
            state_s  = run ? S_FETCH : S_IDLE;
          end
          default: state_s = S_IDLE;
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (op_r == OP_SW) begin
            retire_s = 1'b1;
            state_s  = run ? S_FETCH : S_IDLE;
          end else begin
            state_s = S_WB;
          end
        end else if (tmo_r >= TMO_LAST) begin
          state_s = S_FAULT;
        end else begin
          tmo_s = tmo_r + 8'd1;
        end
      end
      S_WB: begin
        retire_s = 1'b1;
        state_s  = run ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        state_s = S_FAULT;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    case (state_s)
      S_FETCH: ir_we_s = 1'b1;
      S_EXEC: begin
        alu_src_s = (op_s == OP_LW) || (op_s == OP_SW);
        if (op_s == OP_J) begin
          pc_we_s  = 1'b1;
          pc_src_s = 1'b1;
        end else begin
          pc_we_s  = 1'b0;
          pc_src_s = 1'b0;
        end
      end
      S_MEM: begin
        mem_req_s = 1'b1;
        mem_we_s  = (op_s == OP_SW);
      end
      S_WB: begin
        reg_we_s     = 1'b1;
        mem_to_reg_s = (op_s == OP_LW);
        pc_we_s      = 1'b1;
      end
      S_FAULT: fault_s = 1'b1;
      default: ir_we_s = 1'b0;
    endcase

    busy_s = (state_s != S_IDLE) && (state_s != S_FAULT);
  end

  // State, opcode latch, timeout counter and retired counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= S_IDLE;
      op_r      <= 2'b00;
      tmo_r     <= 8'd0;
      retired_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      tmo_r   <= tmo_s;
      if (retire_s) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Registered enables, decoded for the state being entered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ir_we_r      <= 1'b0;
      pc_we_r      <= 1'b0;
      pc_src_r     <= 1'b0;
      reg_we_r     <= 1'b0;
      mem_to_reg_r <= 1'b0;
      alu_src_r    <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      busy_r       <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      ir_we_r      <= ir_we_s;
      pc_we_r      <= pc_we_s;
      pc_src_r     <= pc_src_s;
      reg_we_r     <= reg_we_s;
      mem_to_reg_r <= mem_to_reg_s;
      alu_src_r    <= alu_src_s;
      mem_req_r    <= mem_req_s;
      mem_we_r     <= mem_we_s;
      busy_r       <= busy_s;
      fault_r      <= fault_s;
    end
  end

  assign sw_ack_s   = (state_r == S_MEM) && (op_r == OP_SW) && mem_ack;
  assign ir_we      = ir_we_r;
  assign pc_we      = pc_we_r | sw_ack_s;
  assign pc_src     = pc_src_r;
  assign reg_we     = reg_we_r;
  assign mem_to_reg = mem_to_reg_r;
  assign alu_src    = alu_src_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign busy       = busy_r;
  assign fault      = fault_r;
  assign state      = state_r;
  assign retired    = retired_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl (MEM_TIMEOUT=16, CNT_W=8). Outputs are
// packed into one vector and compared against hand-computed constants.
// Vector bit order: ir_we pc_we pc_src reg_we mem_to_reg alu_src mem_req
// mem_we busy fault.

module tb_multicycle_ctrl;

  logic       CLK, RST, run, step, mem_ack;
  logic [1:0] opcode;
  logic       ir_we, pc_we, pc_src, reg_we, mem_to_reg, alu_src;
  logic       mem_req, mem_we, busy, fault;
  logic [2:0] state;
  logic [7:0] retired;
  logic [9:0] ov;

  int tests = 0;
  int fails = 0;

  localparam logic [9:0] V_IDLE   = 10'b0000000000;
  localparam logic [9:0] V_FETCH  = 10'b1000000010;
  localparam logic [9:0] V_DEC    = 10'b0000000010;
  localparam logic [9:0] V_EX_ADD = 10'b0000000010;
  localparam logic [9:0] V_EX_MEM = 10'b0000010010;
  localparam logic [9:0] V_EX_J   = 10'b0110000010;
  localparam logic [9:0] V_MEM_LW = 10'b0000001010;
  localparam logic [9:0] V_MEM_SA = 10'b0100001110;
  localparam logic [9:0] V_WB_ADD = 10'b0101000010;
  localparam logic [9:0] V_WB_LW  = 10'b0101100010;
  localparam logic [9:0] V_FAULT  = 10'b0000000001;

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .run(run), .step(step), .opcode(opcode),
    .mem_ack(mem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .reg_we(reg_we), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .mem_req(mem_req), .mem_we(mem_we), .busy(busy), .fault(fault),
    .state(state), .retired(retired)
  );

  assign ov = {ir_we, pc_we, pc_src, reg_we, mem_to_reg, alu_src,
               mem_req, mem_we, busy, fault};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] st, input logic [9:0] v);
    chk({tag, "_state"}, {29'd0, state}, {29'd0, st});
    chk({tag, "_out"}, {22'd0, ov}, {22'd0, v});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; run = 1'b0; step = 1'b0; mem_ack = 1'b0; opcode = 2'b00;
    #2 RST = 1'b0;
    #1;
    chk_st("rst_hold", 3'd0, V_IDLE);
    chk("rst_retired", {24'd0, retired}, 32'd0);
    tick();
    RST = 1'b1;

    // Idle for 20 cycles with run=0
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_st("idle", 3'd0, V_IDLE);
    end
    chk("idle_retired", {24'd0, retired}, 32'd0);

    // Three back-to-back adds
    opcode = 2'b00;
    run = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk_st("add_fetch", 3'd1, V_FETCH);
      tick();
      chk_st("add_decode", 3'd2, V_DEC);
      tick();
      chk_st("add_exec", 3'd3, V_EX_ADD);
      tick();
      chk_st("add_wb", 3'd5, V_WB_ADD);
      if (k == 2) run = 1'b0;
      tick();
    end
    chk_st("add_done", 3'd0, V_IDLE);
    chk("add_retired", {24'd0, retired}, 32'd3);

    // lw with ack in the fourth MEM cycle: 8 cycles total
    opcode = 2'b01;
    run = 1'b1;
    tick();
    chk_st("lw_fetch", 3'd1, V_FETCH);
    tick();
    chk_st("lw_decode", 3'd2, V_DEC);
    tick();
    chk_st("lw_exec", 3'd3, V_EX_MEM);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin
        mem_ack = 1'b1;
        #1;
      end
      chk_st("lw_mem", 3'd4, V_MEM_LW);
    end
    tick();
    mem_ack = 1'b0;
    chk_st("lw_wb", 3'd5, V_WB_LW);
    tick();
    chk_st("lw_done", 3'd0, V_IDLE);
    chk("lw_retired", {24'd0, retired}, 32'd4);

    // sw with ack in the same cycle as mem_req
    opcode = 2'b10;
    run = 1'b1;
    tick();
    chk_st("sw_fetch", 3'd1, V_FETCH);
    tick();
    chk_st("sw_decode", 3'd2, V_DEC);
    tick();
    chk_st("sw_exec", 3'd3, V_EX_MEM);
    run = 1'b0;
    tick();
    mem_ack = 1'b1;
    #1;
    chk_st("sw_mem", 3'd4, V_MEM_SA);
    tick();
    mem_ack = 1'b0;
    chk_st("sw_done", 3'd0, V_IDLE);
    chk("sw_retired", {24'd0, retired}, 32'd5);

    // Jump: three cycles, retires in EXEC
    opcode = 2'b11;
    run = 1'b1;
    tick();
    chk_st("j_fetch", 3'd1, V_FETCH);
    tick();
    chk_st("j_decode", 3'd2, V_DEC);
    tick();
    chk_st("j_exec", 3'd3, V_EX_J);
    run = 1'b0;
    tick();
    chk_st("j_done", 3'd0, V_IDLE);
    chk("j_retired", {24'd0, retired}, 32'd6);

    // Single step of one add; a second pulse mid-instruction is ignored
    opcode = 2'b00;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk_st("step_fetch", 3'd1, V_FETCH);
    tick();
    chk_st("step_decode", 3'd2, V_DEC);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk_st("step_exec", 3'd3, V_EX_ADD);
    tick();
    chk_st("step_wb", 3'd5, V_WB_ADD);
    tick();
    chk_st("step_idle0", 3'd0, V_IDLE);
    tick();
    chk_st("step_idle1", 3'd0, V_IDLE);
    chk("step_retired", {24'd0, retired}, 32'd7);

    // lw with no ack: FAULT after 16 MEM cycles, sticky until reset
    opcode = 2'b01;
    run = 1'b1;
    tick();
    chk_st("tmo_fetch", 3'd1, V_FETCH);
    tick();
    chk_st("tmo_decode", 3'd2, V_DEC);
    tick();
    chk_st("tmo_exec", 3'd3, V_EX_MEM);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_st("tmo_mem", 3'd4, V_MEM_LW);
    end
    tick();
    chk_st("tmo_fault", 3'd7, V_FAULT);
    mem_ack = 1'b1;
    step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_st("fault_stuck", 3'd7, V_FAULT);
    end
    chk("fault_retired", {24'd0, retired}, 32'd7);
    RST = 1'b0;
    #1;
    chk_st("fault_rst", 3'd0, V_IDLE);
    chk("fault_rst_ret", {24'd0, retired}, 32'd0);
    mem_ack = 1'b0;
    step = 1'b0;
    run = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    chk_st("post_rst", 3'd0, V_IDLE);

    // Reset asserted mid-MEM drops mem_req before the next edge
    opcode = 2'b01;
    run = 1'b1;
    tick();
    chk_st("rm_fetch", 3'd1, V_FETCH);
    tick();
    tick();
    chk_st("rm_exec", 3'd3, V_EX_MEM);
    tick();
    chk_st("rm_mem", 3'd4, V_MEM_LW);
    #2 RST = 1'b0;
    #1;
    chk_st("rm_async", 3'd0, V_IDLE);
    chk("rm_retired", {24'd0, retired}, 32'd0);
    run = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    chk_st("rm_idle", 3'd0, V_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
